// File: rtl/add_sub_serial_if.sv
// Handshake and result bundle for add_sub_serial.
// master: drives Start/opA/opB/opSel; slave: drives Busy/Done/Sum/Overflow/CarryOut/Zero.
interface add_sub_serial_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opSel;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Overflow;
    logic             CarryOut;
    logic             Zero;

    modport master (
        output Start, opA, opB, opSel,
        input  Busy, Done, Sum, Overflow, CarryOut, Zero
    );

    modport slave (
        input  Start, opA, opB, opSel,
        output Busy, Done, Sum, Overflow, CarryOut, Zero
    );
endinterface

// File: rtl/add_sub_serial.sv
// Multi-cycle signed add/sub, CHUNK bits per clock, carry rippled across cycles.
// Ports: Clk, Rst_n (async low), bus (add_sub_serial_if.slave). Option: ADD_SUB_SAT_EN.
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    add_sub_serial_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, work_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q, cout_q, zero_q;

    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] work_d, sum_fin;
    logic             c_out, c_msb, ovf, last, accept;

    assign accept = bus.Start && (state_q != RUN);
    assign last   = (idx_q == IW'(NCHUNK - 1));

    // Select the active chunk with constant slices
    always_comb begin
        ca = '0;
        cb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign csum  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
    assign c_out = csum[CHUNK];
    // Carry into the chunk MSB recovered from its sum bit
    assign c_msb = ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1];
    assign ovf   = c_msb ^ c_out;

    always_comb begin
        work_d = work_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                work_d[i*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            end
        end
    end

`ifdef ADD_SUB_SAT_EN
    always_comb begin
        sum_fin = work_d;
        if (ovf) begin
            sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_fin = work_d;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.Start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = bus.Start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.opA;
                b_q     <= bus.opB ^ {WIDTH{bus.opSel}};
                carry_q <= bus.opSel;
                idx_q   <= '0;
                work_q  <= '0;
            end else if (state_q == RUN) begin
                work_q  <= work_d;
                carry_q <= c_out;
                idx_q   <= idx_q + 1'b1;
                if (last) begin
                    sum_q  <= sum_fin;
                    cout_q <= c_out;
                    ovf_q  <= ovf;
                    zero_q <= (sum_fin == '0);
                end
            end
        end
    end

    assign bus.Busy     = (state_q == RUN);
    assign bus.Done     = (state_q == DONE);
    assign bus.Sum      = sum_q;
    assign bus.Overflow = ovf_q;
    assign bus.CarryOut = cout_q;
    assign bus.Zero     = zero_q;
endmodule
